// File: rtl/result_trace_buffer.sv
// Trace buffer for ALU results: captures 32-bit words into a circular FIFO and
// drains them MSB-first as a byte stream over a valid/ready handshake.
module result_trace_buffer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       alu_result_i,
    input  logic              capture_en_i,
    input  logic              clear_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W:0]   fifo_count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic [7:0]        drop_count_o
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [31:0]       shreg_reg;
    logic [1:0]        byte_idx_reg;
    logic              overflow_reg;
    logic [7:0]        drop_count_reg;

    logic push, drop, pop, shift, has_data, is_full, handshake;

    // Control: clear wins over everything; a pop only happens on a stored word,
    // so the array is never read before it has been written.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        shift      = 1'b0;
        has_data   = (count_reg != '0);
        is_full    = (count_reg == FULL_COUNT);
        handshake  = (state_reg == SEND) && tx_ready_i;
        push       = capture_en_i && !is_full && !clear_i;
        drop       = capture_en_i && is_full && !clear_i;

        if (clear_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (has_data) begin
                        pop        = 1'b1;
                        state_next = SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (byte_idx_reg != 2'd0) begin
                            shift = 1'b1;
                        end else if (has_data) begin
                            pop = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= alu_result_i;
        end
    end

    // The last byte is left in shreg after the final handshake, so the
    // output holds its value while idle without a separate data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            shreg_reg      <= '0;
            byte_idx_reg   <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (clear_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            byte_idx_reg   <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
                shreg_reg    <= mem[rd_ptr_reg];
                byte_idx_reg <= 2'd3;
            end else if (shift) begin
                shreg_reg    <= {shreg_reg[23:0], 8'h00};
                byte_idx_reg <= byte_idx_reg - 2'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != 8'hFF) begin
                    drop_count_reg <= drop_count_reg + 8'd1;
                end
            end
        end
    end

    assign tx_data_o    = shreg_reg[31:24];
    assign tx_valid_o   = (state_reg == SEND);
    assign fifo_count_o = count_reg;
    assign empty_o      = (count_reg == '0);
    assign full_o       = (count_reg == FULL_COUNT);
    assign overflow_o   = overflow_reg;
    assign drop_count_o = drop_count_reg;

endmodule

// File: tb/tb_result_trace_buffer.sv
// Bench for result_trace_buffer: directed scenarios plus random traffic, all
// checked against a queue-based model of the buffer and byte stream.
module tb_result_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] alu_result = '0;
    logic        capture_en = 1'b0;
    logic        clear = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [4:0]  fifo_count;
    logic        empty, full, overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;

    // Model: stored words, bytes of the word being sent, visible byte, flags.
    logic [31:0] m_q[$];
    logic [7:0]  m_cur[$];
    logic [7:0]  m_data;
    logic        m_ovf;
    int          m_drops;
    logic [7:0]  rx_q[$];

    result_trace_buffer #(.FIFO_DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .alu_result_i(alu_result),
        .capture_en_i(capture_en), .clear_i(clear),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .fifo_count_o(fifo_count), .empty_o(empty), .full_o(full),
        .overflow_o(overflow), .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    function automatic logic [24:0] obs();
        return {tx_valid, tx_data, fifo_count, empty, full, overflow, drop_count};
    endfunction

    function automatic logic [24:0] expv();
        logic [4:0] c;
        c = 5'(m_q.size());
        return {m_cur.size() != 0, m_data, c, m_q.size() == 0, m_q.size() == DEPTH,
                m_ovf, 8'(m_drops)};
    endfunction

    function automatic logic [31:0] rx_word(input int k);
        return {rx_q[4*k], rx_q[4*k+1], rx_q[4*k+2], rx_q[4*k+3]};
    endfunction

    // Drive one cycle (called at posedge+1, returns at posedge+1) and advance the model.
    task automatic step(input logic cap, input logic [31:0] d, input logic rdy, input logic clr);
        bit full_before;
        logic [31:0] w;
        capture_en = cap; alu_result = d; tx_ready = rdy; clear = clr;
        #1;
        if (tx_valid && rdy && !clr) rx_q.push_back(tx_data);
        @(posedge clk);
        if (clr) begin
            m_q.delete(); m_cur.delete(); m_ovf = 1'b0; m_drops = 0;
        end else begin
            full_before = (m_q.size() == DEPTH);
            if (m_cur.size() != 0 && rdy) void'(m_cur.pop_front());
            if (m_cur.size() == 0 && m_q.size() != 0) begin
                w = m_q.pop_front();
                m_cur.push_back(w[31:24]); m_cur.push_back(w[23:16]);
                m_cur.push_back(w[15:8]);  m_cur.push_back(w[7:0]);
            end
            if (cap) begin
                if (full_before) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_q.push_back(d);
                end
            end
            if (m_cur.size() != 0) m_data = m_cur[0];
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        capture_en = 1'b0; clear = 1'b0; tx_ready = 1'b0; alu_result = '0;
        m_q.delete(); m_cur.delete(); m_data = '0; m_ovf = 1'b0; m_drops = 0;
        #2;
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs(), expv());
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (obs() !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%h exp=%h", i, obs(),
                         {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'd0});
            end
        end
    endtask

    task automatic test_single_word();
        rx_q.delete();
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        checks++;
        if (tx_valid !== 1'b0 || fifo_count !== 5'd1) begin
            failures++;
            $display("FAIL single_capture valid=%b count=%0d exp valid=0 count=1", tx_valid, fifo_count);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hDE) begin
            failures++;
            $display("FAIL single_first_byte valid=%b data=%h exp valid=1 data=de", tx_valid, tx_data);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL single_model cycle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (rx_q.size() != 4 || rx_word(0) !== 32'hDEADBEEF || tx_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL single_bytes n=%0d valid=%b empty=%b exp n=4 word=deadbeef valid=0 empty=1",
                     rx_q.size(), tx_valid, empty);
        end
    endtask

    task automatic test_backpressure();
        rx_q.delete();
        step(1'b1, 32'h01234567, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d valid=%b data=%h exp valid=1 data=01", i, tx_valid, tx_data);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stall_model cycle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (rx_q.size() != 4 || rx_word(0) !== 32'h01234567) begin
            failures++;
            $display("FAIL stall_bytes n=%0d exp n=4 word=01234567", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t = 0, vcount = 0, first = -1, last = 0, bad = 0;
        rx_q.delete();
        for (int i = 1; i <= 48; i++) begin
            for (int c = 0; c < 4; c++) begin
                step(i <= 40 && c == 0, 32'(i), 1'b1, 1'b0);
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL b2b_model t=%0d got=%h exp=%h", t, obs(), expv());
                end
                if (tx_valid) begin
                    vcount++;
                    if (first < 0) first = t;
                    last = t;
                end
                t++;
            end
        end
        checks++;
        if (vcount != 160 || last - first + 1 != 160 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stream valid_cycles=%0d span=%0d ovf=%b exp 160 160 0",
                     vcount, last - first + 1, overflow);
        end
        if (rx_q.size() == 160) begin
            for (int k = 0; k < 40; k++) if (rx_word(k) !== 32'(k + 1)) bad++;
        end
        checks++;
        if (rx_q.size() != 160 || bad != 0) begin
            failures++;
            $display("FAIL b2b_bytes n=%0d wrong_words=%0d exp n=160 wrong=0", rx_q.size(), bad);
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        rx_q.delete();
        for (int i = 1; i <= 20; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        checks++;
        if ({full, fifo_count, overflow, drop_count} !== {1'b1, 5'd16, 1'b1, 8'd3}) begin
            failures++;
            $display("FAIL ovf_flags full=%b count=%0d ovf=%b drops=%0d exp 1 16 1 3",
                     full, fifo_count, overflow, drop_count);
        end
        for (int i = 0; i < 72; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL ovf_model cycle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        if (rx_q.size() == 68) begin
            for (int k = 0; k < 17; k++) if (rx_word(k) !== 32'(k + 1)) bad++;
        end
        checks++;
        if (rx_q.size() != 68 || bad != 0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain n=%0d wrong_words=%0d ovf=%b exp n=68 wrong=0 ovf=1",
                     rx_q.size(), bad, overflow);
        end
    endtask

    task automatic test_clear();
        rx_q.delete();
        step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 32'hA3, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (tx_data !== 8'hF0 || fifo_count !== 5'd3) begin
            failures++;
            $display("FAIL clear_setup data=%h count=%0d exp data=f0 count=3", tx_data, fifo_count);
        end
        step(1'b1, 32'h55, 1'b1, 1'b1);
        checks++;
        if ({tx_valid, fifo_count, overflow, drop_count, empty} !== {1'b0, 5'd0, 1'b0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL clear_now valid=%b count=%0d ovf=%b drops=%0d empty=%b exp 0 0 0 0 1",
                     tx_valid, fifo_count, overflow, drop_count, empty);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv() || tx_valid !== 1'b0) begin
                failures++;
                $display("FAIL clear_quiet cycle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        checks++;
        if (rx_q.size() != 2 || {rx_q[0], rx_q[1]} !== 16'hCAFE) begin
            failures++;
            $display("FAIL clear_bytes n=%0d exp n=2 bytes=cafe", rx_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        step(1'b1, 32'h11223344, 1'b0, 1'b0);
        step(1'b1, 32'h55667788, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_mid cycle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        logic cap, rdy, clr;
        for (int i = 0; i < 3000; i++) begin
            cap = ($urandom_range(0, 99) < 40);
            rdy = ($urandom_range(0, 99) < ((i < 1500) ? 25 : 85));
            clr = (i >= 1500) && ($urandom_range(0, 199) == 0);
            step(cap, $urandom, rdy, clr);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_reset_mid_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
